// File: rtl/uart_boot_loader_pkg.sv
// Shared constants and state encodings for the UART boot loader.
// Covers the command and response codes and the parser, RX and TX state enums.
package uart_boot_loader_pkg;

    localparam logic [7:0] CMD_WRITE = 8'hA5;
    localparam logic [7:0] CMD_RUN   = 8'h5A;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        P_IDLE  = 3'd0,
        P_ADDR  = 3'd1,
        P_DATA  = 3'd2,
        P_WRITE = 3'd3,
        P_RUN   = 3'd4
    } parser_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_WAIT  = 3'd1,
        TX_START = 3'd2,
        TX_DATA  = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_t;

    // Serial bits arrive and leave LSB first, so shift registers move right.
    function automatic logic [7:0] shift_in_lsb_first(input logic [7:0] sr, input logic b);
        return {b, sr[7:1]};
    endfunction

endpackage

// File: rtl/uart_loader_rx.sv
// Tick-driven 16x oversampling 8N1 receiver for the boot loader.
// It rejects start-bit glitches and flags framing errors.
module uart_loader_rx
    import uart_boot_loader_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       serial_in,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       w_line;
    logic       w_fall;

    rx_state_t  r_state, w_state_nx;
    logic [3:0] r_tcnt, w_tcnt_nx;
    logic [2:0] r_bcnt, w_bcnt_nx;
    logic [7:0] r_shreg, w_shreg_nx;
    logic [7:0] r_byte, w_byte_nx;
    logic       r_valid, w_valid_nx;
    logic       r_err, w_err_nx;

    // Synchronise the asynchronous line and keep one older copy for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], serial_in};
            r_prev <= r_sync[1];
        end
    end

    assign w_line = r_sync[1];
    assign w_fall = r_prev & ~w_line;

    // Receiver state and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RX_IDLE;
            r_tcnt  <= 4'd0;
            r_bcnt  <= 3'd0;
            r_shreg <= 8'd0;
            r_byte  <= 8'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_tcnt  <= w_tcnt_nx;
            r_bcnt  <= w_bcnt_nx;
            r_shreg <= w_shreg_nx;
            r_byte  <= w_byte_nx;
            r_valid <= w_valid_nx;
            r_err   <= w_err_nx;
        end
    end

    // Next-state logic: the start bit is checked at its centre, and every later bit is sampled 16 ticks on.
    always_comb begin
        w_state_nx = r_state;
        w_tcnt_nx  = r_tcnt;
        w_bcnt_nx  = r_bcnt;
        w_shreg_nx = r_shreg;
        w_byte_nx  = r_byte;
        w_valid_nx = 1'b0;
        w_err_nx   = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_state_nx = RX_START;
                    w_tcnt_nx  = 4'd0;
                end else begin
                    w_state_nx = RX_IDLE;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (r_tcnt == 4'd7) begin
                        w_tcnt_nx  = 4'd0;
                        w_bcnt_nx  = 3'd0;
                        w_state_nx = w_line ? RX_IDLE : RX_DATA;
                    end else begin
                        w_tcnt_nx = r_tcnt + 4'd1;
                    end
                end else begin
                    w_tcnt_nx = r_tcnt;
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (r_tcnt == 4'd15) begin
                        w_tcnt_nx  = 4'd0;
                        w_shreg_nx = shift_in_lsb_first(r_shreg, w_line);
                        if (r_bcnt == 3'd7) begin
                            w_state_nx = RX_STOP;
                        end else begin
                            w_bcnt_nx = r_bcnt + 3'd1;
                        end
                    end else begin
                        w_tcnt_nx = r_tcnt + 4'd1;
                    end
                end else begin
                    w_tcnt_nx = r_tcnt;
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (r_tcnt == 4'd15) begin
                        w_tcnt_nx  = 4'd0;
                        w_state_nx = RX_IDLE;
                        if (w_line) begin
                            w_valid_nx = 1'b1;
                            w_byte_nx  = r_shreg;
                        end else begin
                            w_err_nx = 1'b1;
                        end
                    end else begin
                        w_tcnt_nx = r_tcnt + 4'd1;
                    end
                end else begin
                    w_tcnt_nx = r_tcnt;
                end
            end
            default: begin
                w_state_nx = RX_IDLE;
            end
        endcase
    end

    assign rx_byte  = r_byte;
    assign rx_valid = r_valid;
    assign rx_err   = r_err;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: it holds the core in reset, writes framed words into memory and answers each frame with ACK or NAK.
// The top contains the tick generator, the command parser, the one-entry response buffer and the transmitter.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          ADDR_WIDTH = 16,
    parameter int          DVSR       = 26,
    parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  serial_in,
    output logic                  serial_out,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0]      mem_w_data,
    output logic                  mem_w_en,
    output logic                  core_reset_n,
    output logic                  busy
);

    localparam int DIV_W      = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int ADDR_BYTES = ADDR_WIDTH / 8;
    localparam int DATA_BYTES = WIDTH / 8;

    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_err;
    logic [7:0] r_byte_d;
    logic       r_byte_v;
    logic       r_err_d;

    parser_state_t         r_pstate, w_pnext;
    logic [2:0]            r_bcnt, w_bcnt_nx;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx;
    logic [WIDTH-1:0]      r_data, w_data_nx;
    logic [15:0]           r_to_cnt;
    logic                  w_timeout;
    logic                  w_rsp_v;
    logic [7:0]            w_rsp;
    logic                  w_wr;

    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [WIDTH-1:0]      r_mem_w_data;
    logic                  r_mem_w_en;
    logic                  r_core_rst_n;
    logic                  r_busy;

    tx_state_t  r_tx_state, w_tx_state_nx;
    logic [3:0] r_tx_cnt, w_tx_cnt_nx;
    logic [2:0] r_tx_bit, w_tx_bit_nx;
    logic [7:0] r_tx_sh, w_tx_sh_nx;
    logic       r_tx_out, w_tx_out_nx;
    logic       r_pend_v;
    logic [7:0] r_pend;
    logic       w_tx_free;
    logic       w_load;
    logic [7:0] w_load_byte;

    // Oversampling tick divider.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div <= {DIV_W{1'b0}};
        end else begin
            r_div <= w_tick ? {DIV_W{1'b0}} : r_div + DIV_W'(1);
        end
    end

    assign w_tick = (r_div == DIV_W'(DVSR - 1));

    uart_loader_rx u_rx (
        .clock     (clock),
        .reset     (reset),
        .tick      (w_tick),
        .serial_in (serial_in),
        .rx_byte   (w_rx_byte),
        .rx_valid  (w_rx_valid),
        .rx_err    (w_rx_err)
    );

    assign w_timeout = (r_to_cnt == TIMEOUT) && !r_byte_v;

    // Parser next state: the byte counter is cleared whenever the parser returns to IDLE.
    always_comb begin
        w_pnext   = r_pstate;
        w_bcnt_nx = r_bcnt;
        w_addr_nx = r_addr;
        w_data_nx = r_data;
        w_rsp_v   = 1'b0;
        w_rsp     = RSP_ACK;
        w_wr      = 1'b0;
        case (r_pstate)
            P_IDLE: begin
                w_bcnt_nx = 3'd0;
                if (r_byte_v) begin
                    if (r_byte_d == CMD_WRITE) begin
                        w_pnext = P_ADDR;
                    end else if (r_byte_d == CMD_RUN) begin
                        w_pnext = P_RUN;
                    end else begin
                        w_rsp_v = 1'b1;
                        w_rsp   = RSP_NAK;
                    end
                end else if (r_err_d) begin
                    w_rsp_v = 1'b1;
                    w_rsp   = RSP_NAK;
                end else begin
                    w_pnext = P_IDLE;
                end
            end
            P_ADDR: begin
                if (r_byte_v) begin
                    w_addr_nx = {r_addr[ADDR_WIDTH-9:0], r_byte_d};
                    if (r_bcnt == 3'(ADDR_BYTES - 1)) begin
                        w_pnext   = P_DATA;
                        w_bcnt_nx = 3'd0;
                    end else begin
                        w_bcnt_nx = r_bcnt + 3'd1;
                    end
                end else if (r_err_d || w_timeout) begin
                    w_pnext   = P_IDLE;
                    w_bcnt_nx = 3'd0;
                    w_rsp_v   = 1'b1;
                    w_rsp     = RSP_NAK;
                end else begin
                    w_pnext = P_ADDR;
                end
            end
            P_DATA: begin
                if (r_byte_v) begin
                    w_data_nx = {r_data[WIDTH-9:0], r_byte_d};
                    if (r_bcnt == 3'(DATA_BYTES - 1)) begin
                        w_pnext   = P_WRITE;
                        w_bcnt_nx = 3'd0;
                        w_wr      = 1'b1;
                    end else begin
                        w_bcnt_nx = r_bcnt + 3'd1;
                    end
                end else if (r_err_d || w_timeout) begin
                    w_pnext   = P_IDLE;
                    w_bcnt_nx = 3'd0;
                    w_rsp_v   = 1'b1;
                    w_rsp     = RSP_NAK;
                end else begin
                    w_pnext = P_DATA;
                end
            end
            P_WRITE: begin
                w_pnext = P_IDLE;
                w_rsp_v = 1'b1;
                w_rsp   = RSP_ACK;
            end
            P_RUN: begin
                w_pnext = P_IDLE;
                w_rsp_v = 1'b1;
                w_rsp   = RSP_ACK;
            end
            default: begin
                w_pnext   = P_IDLE;
                w_bcnt_nx = 3'd0;
            end
        endcase
    end

    // Parser registers, memory-side outputs, core release and the timeout counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_byte_d      <= 8'd0;
            r_byte_v      <= 1'b0;
            r_err_d       <= 1'b0;
            r_pstate      <= P_IDLE;
            r_bcnt        <= 3'd0;
            r_addr        <= {ADDR_WIDTH{1'b0}};
            r_data        <= {WIDTH{1'b0}};
            r_to_cnt      <= 16'd0;
            r_mem_address <= {ADDR_WIDTH{1'b0}};
            r_mem_w_data  <= {WIDTH{1'b0}};
            r_mem_w_en    <= 1'b0;
            r_core_rst_n  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_byte_d   <= w_rx_byte;
            r_byte_v   <= w_rx_valid;
            r_err_d    <= w_rx_err;
            r_pstate   <= w_pnext;
            r_bcnt     <= w_bcnt_nx;
            r_addr     <= w_addr_nx;
            r_data     <= w_data_nx;
            r_mem_w_en <= w_wr;
            if (w_wr) begin
                r_mem_address <= w_addr_nx;
                r_mem_w_data  <= w_data_nx;
            end
            if (r_pstate == P_RUN) begin
                r_core_rst_n <= 1'b1;
            end
            if ((r_pstate == P_ADDR || r_pstate == P_DATA) && w_pnext != P_IDLE) begin
                if (r_byte_v) begin
                    r_to_cnt <= 16'd0;
                end else if (w_tick) begin
                    r_to_cnt <= r_to_cnt + 16'd1;
                end
            end else begin
                r_to_cnt <= 16'd0;
            end
            // A new frame keeps busy set even if an older response drains in the same cycle.
            if (w_load && w_pnext == P_IDLE) begin
                r_busy <= 1'b0;
            end else if (r_pstate == P_IDLE && r_byte_v) begin
                r_busy <= 1'b1;
            end
        end
    end

    assign w_tx_free   = (r_tx_state == TX_IDLE) ||
                         (r_tx_state == TX_STOP && w_tick && r_tx_cnt == 4'd15);
    assign w_load      = w_tx_free && (w_rsp_v || r_pend_v);
    assign w_load_byte = w_rsp_v ? w_rsp : r_pend;

    // Transmitter next state: a loaded byte waits for the next tick before its start bit.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_sh_nx    = r_tx_sh;
        w_tx_out_nx   = r_tx_out;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_out_nx = 1'b1;
                if (w_load) begin
                    w_tx_state_nx = TX_WAIT;
                    w_tx_sh_nx    = w_load_byte;
                end else begin
                    w_tx_state_nx = TX_IDLE;
                end
            end
            TX_WAIT: begin
                if (w_tick) begin
                    w_tx_state_nx = TX_START;
                    w_tx_cnt_nx   = 4'd0;
                    w_tx_out_nx   = 1'b0;
                end else begin
                    w_tx_state_nx = TX_WAIT;
                end
            end
            TX_START: begin
                if (w_tick) begin
                    if (r_tx_cnt == 4'd15) begin
                        w_tx_state_nx = TX_DATA;
                        w_tx_cnt_nx   = 4'd0;
                        w_tx_bit_nx   = 3'd0;
                        w_tx_out_nx   = r_tx_sh[0];
                    end else begin
                        w_tx_cnt_nx = r_tx_cnt + 4'd1;
                    end
                end else begin
                    w_tx_cnt_nx = r_tx_cnt;
                end
            end
            TX_DATA: begin
                if (w_tick) begin
                    if (r_tx_cnt == 4'd15) begin
                        w_tx_cnt_nx = 4'd0;
                        if (r_tx_bit == 3'd7) begin
                            w_tx_state_nx = TX_STOP;
                            w_tx_out_nx   = 1'b1;
                        end else begin
                            w_tx_bit_nx = r_tx_bit + 3'd1;
                            w_tx_sh_nx  = {1'b1, r_tx_sh[7:1]};
                            w_tx_out_nx = r_tx_sh[1];
                        end
                    end else begin
                        w_tx_cnt_nx = r_tx_cnt + 4'd1;
                    end
                end else begin
                    w_tx_cnt_nx = r_tx_cnt;
                end
            end
            TX_STOP: begin
                if (w_tick && r_tx_cnt == 4'd15) begin
                    w_tx_cnt_nx = 4'd0;
                    if (w_load) begin
                        w_tx_state_nx = TX_WAIT;
                        w_tx_sh_nx    = w_load_byte;
                    end else begin
                        w_tx_state_nx = TX_IDLE;
                    end
                end else if (w_tick) begin
                    w_tx_cnt_nx = r_tx_cnt + 4'd1;
                end else begin
                    w_tx_cnt_nx = r_tx_cnt;
                end
            end
            default: begin
                w_tx_state_nx = TX_IDLE;
                w_tx_out_nx   = 1'b1;
            end
        endcase
    end

    // Transmitter registers and the single pending-response slot (a newer response overwrites it).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 4'd0;
            r_tx_bit   <= 3'd0;
            r_tx_sh    <= 8'd0;
            r_tx_out   <= 1'b1;
            r_pend_v   <= 1'b0;
            r_pend     <= 8'd0;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_sh    <= w_tx_sh_nx;
            r_tx_out   <= w_tx_out_nx;
            if (w_rsp_v && !w_tx_free) begin
                r_pend_v <= 1'b1;
                r_pend   <= w_rsp;
            end else if (w_load) begin
                r_pend_v <= 1'b0;
            end
        end
    end

    assign serial_out   = r_tx_out;
    assign mem_address  = r_mem_address;
    assign mem_w_data   = r_mem_w_data;
    assign mem_w_en     = r_mem_w_en;
    assign core_reset_n = r_core_rst_n;
    assign busy         = r_busy;

endmodule
